// File: rtl/div_sched_if.sv
// div_sched_if: groups the EX-side request/response handshake and the two
// divider cores' AXI-stream signals that the scheduler sits between.
interface div_sched_if;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_signed;
    logic        req_mod;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        sdiv_tvalid;
    logic        sdiv_tready;
    logic        sdiv_dout_tvalid;
    logic [63:0] sdiv_dout_tdata;
    logic        udiv_tvalid;
    logic        udiv_tready;
    logic        udiv_dout_tvalid;
    logic [63:0] udiv_dout_tdata;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        busy;

    // scheduler view
    modport slave (
        input  flush, req_valid, req_signed, req_mod, req_dividend, req_divisor,
               resp_ready, sdiv_tready, sdiv_dout_tvalid, sdiv_dout_tdata,
               udiv_tready, udiv_dout_tvalid, udiv_dout_tdata,
        output req_ready, resp_valid, resp_data, sdiv_tvalid, udiv_tvalid,
               div_dividend, div_divisor, busy
    );

    // EX stage plus divider cores view
    modport master (
        output flush, req_valid, req_signed, req_mod, req_dividend, req_divisor,
               resp_ready, sdiv_tready, sdiv_dout_tvalid, sdiv_dout_tdata,
               udiv_tready, udiv_dout_tvalid, udiv_dout_tdata,
        input  req_ready, resp_valid, resp_data, sdiv_tvalid, udiv_tvalid,
               div_dividend, div_divisor, busy
    );
endinterface

// File: rtl/div_sched.sv
// div_sched: accepts one div/mod op from EX, issues it to the signed or
// unsigned divider core, returns quotient or remainder. A flushed op keeps
// running in the core (it cannot be cancelled) and its result is drained.
// Division by zero is answered locally when ZERO_BYPASS is set.
module div_sched #(
    parameter int ZERO_BYPASS = 1
) (
    input logic        clk,
    input logic        rst,
    div_sched_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        op_signed;
    logic        op_mod;
    logic        drop;
    logic [31:0] op_dividend;
    logic [31:0] op_divisor;
    logic [31:0] result;
    logic        accept;
    logic        bypass;
    logic        sel_tready;
    logic        sel_dout_valid;
    logic [63:0] sel_dout_data;

    // flush wins over a new acceptance in the same cycle
    assign accept = (state == S_IDLE) && bus.req_valid && !bus.flush;
    assign bypass = (ZERO_BYPASS != 0) && (bus.req_divisor == 32'd0);

    // only the core that owns the current op is listened to
    assign sel_tready     = op_signed ? bus.sdiv_tready      : bus.udiv_tready;
    assign sel_dout_valid = op_signed ? bus.sdiv_dout_tvalid : bus.udiv_dout_tvalid;
    assign sel_dout_data  = op_signed ? bus.sdiv_dout_tdata  : bus.udiv_dout_tdata;

    assign bus.resp_data    = result;
    assign bus.div_dividend = op_dividend;
    assign bus.div_divisor  = op_divisor;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = bypass ? S_DONE : S_ISSUE;
            S_ISSUE: if (sel_tready) state_nxt = (drop || bus.flush) ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (sel_dout_valid) state_nxt = bus.flush ? S_IDLE : S_DONE;
                else if (bus.flush) state_nxt = S_DRAIN;
            end
            S_DONE:  if (bus.flush || bus.resp_ready) state_nxt = S_IDLE;
            S_DRAIN: if (sel_dout_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // operand/result capture and the sticky drop flag for flushes during issue
    always_ff @(posedge clk) begin
        if (rst) begin
            op_signed   <= 1'b0;
            op_mod      <= 1'b0;
            op_dividend <= 32'd0;
            op_divisor  <= 32'd0;
            result      <= 32'd0;
            drop        <= 1'b0;
        end else begin
            if (accept) begin
                op_signed   <= bus.req_signed;
                op_mod      <= bus.req_mod;
                op_dividend <= bus.req_dividend;
                op_divisor  <= bus.req_divisor;
                drop        <= 1'b0;
                if (bypass) result <= bus.req_mod ? bus.req_dividend : 32'hFFFF_FFFF;
            end
            if (state == S_ISSUE && bus.flush) drop <= 1'b1;
            if (state == S_WAIT && sel_dout_valid && !bus.flush)
                result <= op_mod ? sel_dout_data[31:0] : sel_dout_data[63:32];
        end
    end

    // outputs decoded from the current state
    always_comb begin
        bus.req_ready   = (state == S_IDLE) && !bus.flush;
        bus.resp_valid  = (state == S_DONE);
        bus.sdiv_tvalid = (state == S_ISSUE) && op_signed;
        bus.udiv_tvalid = (state == S_ISSUE) && !op_signed;
        bus.busy        = (state != S_IDLE);
    end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed scenarios plus randomized traffic against a
// transaction-level model of the scheduler and behavioural divider cores.
module tb_div_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_sched_if bus();
    div_sched #(.ZERO_BYPASS(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    // stimulus drive values for the next clock edge
    logic        d_rst, d_flush, d_req_valid, d_signed, d_mod, d_resp_ready;
    logic [31:0] d_a, d_b;
    int          tready_force, lat_force;
    bit          junk_en, chk_en;

    // behavioural cores: index 0 unsigned, 1 signed
    bit          cbusy[2];
    int          ccnt[2];
    logic [63:0] cdata[2];
    logic        dv[2], tr[2];
    logic [63:0] dd[2];

    // transaction model of the op held by the scheduler
    bit          m_have, m_signed, m_mod, m_sent, m_kill, m_ready, m_acc;
    logic [31:0] m_a, m_b, m_res;

    // observed activity, for scenario-level checks
    int          o_stv, o_utv, o_resp;
    logic [31:0] o_last;

    function automatic logic [63:0] core_fn(input int c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        if (b == 32'd0)  q = 32'hFFFF_FFFF;
        else if (c == 1) q = 32'($signed(a) / $signed(b));
        else             q = a / b;
        return {q, a - q * b};
    endfunction

    function automatic logic [31:0] ref_result(input bit s, input bit md, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb;
        if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
        sa = a;
        sb = b;
        if (s) return md ? 32'(sa % sb) : 32'(sa / sb);
        return md ? a % b : a / b;
    endfunction

    task automatic clr_obs();
        o_stv = 0; o_utv = 0; o_resp = 0; o_last = 32'd0;
    endtask

    task automatic step();
        logic tv[2];
        int   sel;
        @(negedge clk);
        tv[0] = bus.udiv_tvalid;
        tv[1] = bus.sdiv_tvalid;
        for (int c = 0; c < 2; c++) begin
            dv[c] = 1'b0;
            dd[c] = 64'd0;
            if (cbusy[c]) begin
                if (ccnt[c] == 0) begin
                    dv[c] = 1'b1; dd[c] = cdata[c]; cbusy[c] = 1'b0;
                end else ccnt[c]--;
            end else if (junk_en && m_have && int'(m_signed) != c && $urandom_range(0, 7) == 0) begin
                dv[c] = 1'b1; dd[c] = {$urandom(), $urandom()};
            end
            if (cbusy[c])              tr[c] = 1'b0;
            else if (tready_force >= 0) tr[c] = (tready_force != 0);
            else                        tr[c] = ($urandom_range(0, 2) != 0);
            if (d_rst) begin
                tr[c] = 1'b0; dv[c] = 1'b0; cbusy[c] = 1'b0;
            end else if (tv[c] && tr[c]) begin
                cbusy[c] = 1'b1;
                ccnt[c]  = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
                cdata[c] = core_fn(c, bus.div_dividend, bus.div_divisor);
            end
        end
        rst                  = d_rst;
        bus.flush            = d_flush;
        bus.req_valid        = d_req_valid;
        bus.req_signed       = d_signed;
        bus.req_mod          = d_mod;
        bus.req_dividend     = d_a;
        bus.req_divisor      = d_b;
        bus.resp_ready       = d_resp_ready;
        bus.udiv_tready      = tr[0];
        bus.sdiv_tready      = tr[1];
        bus.udiv_dout_tvalid = dv[0];
        bus.udiv_dout_tdata  = dd[0];
        bus.sdiv_dout_tvalid = dv[1];
        bus.sdiv_dout_tdata  = dd[1];
        #1;
        if (chk_en) begin
            chk("req_ready",  64'(bus.req_ready),   64'(!m_have && !d_flush));
            chk("resp_valid", 64'(bus.resp_valid),  64'(m_have && m_ready));
            chk("sdiv_tvalid", 64'(bus.sdiv_tvalid), 64'(m_have && !m_ready && !m_sent && m_signed));
            chk("udiv_tvalid", 64'(bus.udiv_tvalid), 64'(m_have && !m_ready && !m_sent && !m_signed));
            chk("busy",       64'(bus.busy),        64'(m_have));
            chk("div_dividend", 64'(bus.div_dividend), 64'(m_a));
            chk("div_divisor",  64'(bus.div_divisor),  64'(m_b));
            if (m_have && m_ready) chk("resp_data", 64'(bus.resp_data), 64'(m_res));
        end
        if (bus.sdiv_tvalid) o_stv++;
        if (bus.udiv_tvalid) o_utv++;
        if (bus.resp_valid) begin
            o_resp++; o_last = bus.resp_data;
        end
        // model advance across the coming edge
        sel   = m_signed ? 1 : 0;
        m_acc = 1'b0;
        if (d_rst) begin
            m_have = 0; m_signed = 0; m_mod = 0; m_sent = 0; m_kill = 0; m_ready = 0;
            m_a = 32'd0; m_b = 32'd0;
        end else if (m_have) begin
            if (m_ready) begin
                if (d_flush || d_resp_ready) begin
                    m_have = 0; m_ready = 0;
                end
            end else if (!m_sent) begin
                if (d_flush) m_kill = 1;
                if (tr[sel]) m_sent = 1;
            end else if (dv[sel]) begin
                if (m_kill || d_flush) m_have = 0;
                else begin
                    m_ready = 1; m_res = ref_result(m_signed, m_mod, m_a, m_b);
                end
            end else if (d_flush) m_kill = 1;
        end else if (d_req_valid && !d_flush) begin
            m_acc = 1; m_have = 1; m_signed = d_signed; m_mod = d_mod;
            m_a = d_a; m_b = d_b; m_sent = 0; m_kill = 0;
            m_ready = (d_b == 32'd0);
            if (m_ready) m_res = ref_result(d_signed, d_mod, d_a, d_b);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic send(input bit s, input bit md, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        d_req_valid = 1'b1; d_signed = s; d_mod = md; d_a = a; d_b = b;
        do begin
            step(); n++;
        end while (!m_acc && n < 20);
        chk("accept", 64'(m_acc), 64'd1);
        d_req_valid = 1'b0;
    endtask

    initial begin
        d_rst = 1; d_flush = 0; d_req_valid = 0; d_signed = 0; d_mod = 0;
        d_a = 32'd0; d_b = 32'd0; d_resp_ready = 1;
        tready_force = 1; lat_force = 0; junk_en = 0; chk_en = 0;
        m_have = 0; m_signed = 0; m_mod = 0; m_sent = 0; m_kill = 0; m_ready = 0; m_acc = 0;
        m_a = 32'd0; m_b = 32'd0; m_res = 32'd0;
        clr_obs();
        step();
        chk_en = 1;
        d_rst = 0;
        step();
        chk("rst_busy",       64'(bus.busy),         64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid),   64'd0);
        chk("rst_req_ready",  64'(bus.req_ready),    64'd1);
        chk("rst_resp_data",  64'(bus.resp_data),    64'd0);
        chk("rst_dividend",   64'(bus.div_dividend), 64'd0);

        // signed 7 / -2
        clr_obs();
        send(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE);
        run(6);
        chk("t1_sdiv_cycles", 64'(o_stv), 64'd1);
        chk("t1_udiv_cycles", 64'(o_utv), 64'd0);
        chk("t1_resp_count",  64'(o_resp), 64'd1);
        chk("t1_data",        64'(o_last), 64'hFFFF_FFFD);

        // unsigned FFFFFFFF mod 10 with tready low for 3 cycles
        tready_force = 0;
        clr_obs();
        send(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd10);
        run(3);
        tready_force = 1;
        run(6);
        chk("t2_udiv_cycles", 64'(o_utv), 64'd4);
        chk("t2_sdiv_cycles", 64'(o_stv), 64'd0);
        chk("t2_resp_count",  64'(o_resp), 64'd1);
        chk("t2_data",        64'(o_last), 64'd5);

        // divide by zero, both quotient and remainder
        clr_obs();
        send(1'b0, 1'b0, 32'd123, 32'd0);
        run(3);
        chk("t3_no_issue",   64'(o_stv + o_utv), 64'd0);
        chk("t3_resp_count", 64'(o_resp), 64'd1);
        chk("t3_quot",       64'(o_last), 64'hFFFF_FFFF);
        clr_obs();
        send(1'b1, 1'b1, 32'd123, 32'd0);
        run(3);
        chk("t3_mod_no_issue", 64'(o_stv + o_utv), 64'd0);
        chk("t3_mod",          64'(o_last), 64'd123);

        // flush in WAIT, then 20/4 right behind it
        lat_force = 3;
        clr_obs();
        send(1'b1, 1'b0, 32'd100, 32'd7);
        step();
        d_flush = 1;
        step();
        d_flush = 0;
        send(1'b0, 1'b0, 32'd20, 32'd4);
        run(8);
        chk("t4_resp_count", 64'(o_resp), 64'd1);
        chk("t4_data",       64'(o_last), 64'd5);

        // flush during ISSUE while tready is low for 2 cycles
        lat_force = 1;
        tready_force = 0;
        clr_obs();
        send(1'b1, 1'b1, 32'hFFFF_FFF7, 32'd4);
        d_flush = 1;
        step();
        d_flush = 0;
        step();
        tready_force = 1;
        run(8);
        chk("t5_sdiv_cycles", 64'(o_stv), 64'd3);
        chk("t5_resp_count",  64'(o_resp), 64'd0);
        chk("t5_busy",        64'(bus.busy), 64'd0);

        // DONE held under back-pressure, then reset
        lat_force = 0;
        d_resp_ready = 0;
        send(1'b0, 1'b0, 32'd1000, 32'd7);
        run(2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_hold_valid", 64'(bus.resp_valid), 64'd1);
            chk("t6_hold_data",  64'(bus.resp_data),  64'd142);
        end
        d_rst = 1;
        step();
        d_rst = 0;
        step();
        chk("t6_rst_resp_valid", 64'(bus.resp_valid),   64'd0);
        chk("t6_rst_resp_data",  64'(bus.resp_data),    64'd0);
        chk("t6_rst_busy",       64'(bus.busy),         64'd0);
        chk("t6_rst_tvalid",     64'(bus.sdiv_tvalid | bus.udiv_tvalid), 64'd0);
        chk("t6_rst_dividend",   64'(bus.div_dividend), 64'd0);
        chk("t6_rst_divisor",    64'(bus.div_divisor),  64'd0);

        // randomized traffic
        tready_force = -1;
        lat_force = -1;
        junk_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!d_req_valid || m_acc || $urandom_range(0, 3) == 0) begin
                int r;
                d_req_valid = ($urandom_range(0, 1) == 1);
                d_signed    = ($urandom_range(0, 1) == 1);
                d_mod       = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 3) == 0) d_a = 32'($urandom_range(0, 50));
                else                           d_a = $urandom();
                r = int'($urandom_range(0, 7));
                if (r == 0)     d_b = 32'd0;
                else if (r < 4) d_b = 32'($urandom_range(1, 20));
                else            d_b = $urandom();
                if (d_a == 32'h8000_0000 && d_b == 32'hFFFF_FFFF) d_b = 32'd3;
            end
            d_flush      = ($urandom_range(0, 19) == 0);
            d_resp_ready = ($urandom_range(0, 9) < 7);
            d_rst        = ($urandom_range(0, 499) == 0);
            step();
        end
        d_rst = 0; d_flush = 0; d_req_valid = 0; d_resp_ready = 1;
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
